// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game-flow FSM (WELCOME/START/PLAY/PAUSE/FINISH).
// Owns team-name entry, the start countdown, the round timer and pause
// arbitration, and drives freeze/reset controls to the rest of the game.
// Everything runs on the system clock; frame_tick_i is a one-cycle strobe
// per video frame.
// Optional feature: define GAME_FLOW_HISCORE_EN to build the best-score
// register; otherwise best_score_o is tied to 0.
//
// Handshake note: there is no valid/ready traffic here. Buttons are levels;
// a press is the first clock on which a level is seen high (btn & ~prev),
// and the FSM acts on that same edge, so outputs move one clock after the
// rising level. A held button never repeats.
module game_flow_ctrl #(
   parameter int NUM_PLAYERS    = 4,
   parameter int NAME_LEN       = 3,
   parameter int START_FRAMES   = 300,
   parameter int FRAMES_PER_SEC = 60,
   parameter int GAME_SECONDS   = 180,
   localparam int PW     = $clog2(NUM_PLAYERS + 1),
   localparam int TIME_W = $clog2(GAME_SECONDS + 1),
   localparam int CUR_W  = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1
) (
   input  logic                    clock_i,
   input  logic                    reset_ni,
   input  logic                    frame_tick_i,
   input  logic [PW-1:0]           num_players_i,
   input  logic [NUM_PLAYERS-1:0]  left_i,
   input  logic [NUM_PLAYERS-1:0]  right_i,
   input  logic [NUM_PLAYERS-1:0]  up_i,
   input  logic [NUM_PLAYERS-1:0]  down_i,
   input  logic [NUM_PLAYERS-1:0]  chop_i,
   input  logic [NUM_PLAYERS-1:0]  carry_i,
   input  logic [9:0]              score_i,
   output logic [2:0]              game_state_o,
   output logic [NAME_LEN*8-1:0]   team_name_o,
   output logic [CUR_W-1:0]        name_cursor_o,
   output logic [TIME_W-1:0]       time_left_o,
   output logic                    timer_go_o,
   output logic                    players_frozen_o,
   output logic                    round_reset_o,
   output logic [9:0]              best_score_o
);

   localparam int SC_W = $clog2(START_FRAMES + 1);
   localparam int FC_W = $clog2(FRAMES_PER_SEC + 1);
   localparam int OW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   localparam logic [7:0]        CH_A       = 8'h41;
   localparam logic [7:0]        CH_Z       = 8'h5A;
   localparam logic [TIME_W-1:0] TIME_INIT  = TIME_W'(GAME_SECONDS);
   localparam logic [SC_W-1:0]   START_LAST = SC_W'(START_FRAMES - 1);
   localparam logic [SC_W-1:0]   START_DONE = SC_W'(START_FRAMES);
   localparam logic [FC_W-1:0]   FRAME_LAST = FC_W'(FRAMES_PER_SEC - 1);
   localparam logic [CUR_W-1:0]  CUR_LAST   = CUR_W'(NAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_WELCOME = 3'd0,
      ST_START   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_FINISH  = 3'd4
   } state_e;

   state_e state_q, state_d;

   logic [NUM_PLAYERS-1:0] left_prev_q, right_prev_q, up_prev_q;
   logic [NUM_PLAYERS-1:0] down_prev_q, chop_prev_q, carry_prev_q;
   logic [NUM_PLAYERS-1:0] active_mask;
   logic [NUM_PLAYERS-1:0] p_left, p_right, p_up, p_down, p_chop, p_carry;

   logic [NAME_LEN-1:0][7:0] name_q, name_d;
   logic [CUR_W-1:0]         cursor_q, cursor_d;
   logic [TIME_W-1:0]        time_left_q, time_left_d;
   logic [SC_W-1:0]          start_cnt_q, start_cnt_d;
   logic [FC_W-1:0]          frame_cnt_q, frame_cnt_d;
   logic [OW-1:0]            owner_q, owner_d;
   logic [PW-1:0]            active_q, active_d;
   logic                     round_reset_q, round_reset_d;

   logic [PW-1:0]            nump_eff;
   logic                     pause_req;
   logic [OW-1:0]            pause_idx;

   // Only player 0 navigates the name; the other players' nav bits are unused.
   logic unused_nav;
   assign unused_nav = ^{p_left, p_right, p_up, p_down};

   // Players with index below the latched active count may generate events.
   always_comb begin
      active_mask = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         active_mask[i] = (int'(active_q) > i);
      end
   end

   assign p_left  = left_i  & ~left_prev_q  & active_mask;
   assign p_right = right_i & ~right_prev_q & active_mask;
   assign p_up    = up_i    & ~up_prev_q    & active_mask;
   assign p_down  = down_i  & ~down_prev_q  & active_mask;
   assign p_chop  = chop_i  & ~chop_prev_q  & active_mask;
   assign p_carry = carry_i & ~carry_prev_q & active_mask;

   // 0 players counts as 1; anything above NUM_PLAYERS is clamped.
   assign nump_eff = (num_players_i == '0) ? PW'(1) :
                     (int'(num_players_i) > NUM_PLAYERS) ? PW'(NUM_PLAYERS) :
                     num_players_i;

   // Pause request: chop and carry both held, one of them newly pressed;
   // descending scan leaves the lowest requesting index in pause_idx.
   always_comb begin
      pause_req = 1'b0;
      pause_idx = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (chop_i[i] && carry_i[i] && active_mask[i] && (p_chop[i] || p_carry[i])) begin
            pause_req = 1'b1;
            pause_idx = OW'(i);
         end
      end
   end

   // Button history: every bus is sampled every clock.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         left_prev_q  <= '0;
         right_prev_q <= '0;
         up_prev_q    <= '0;
         down_prev_q  <= '0;
         chop_prev_q  <= '0;
         carry_prev_q <= '0;
      end else begin
         left_prev_q  <= left_i;
         right_prev_q <= right_i;
         up_prev_q    <= up_i;
         down_prev_q  <= down_i;
         chop_prev_q  <= chop_i;
         carry_prev_q <= carry_i;
      end
   end

   // Next-state and datapath updates for the game-flow FSM.
   always_comb begin
      state_d       = state_q;
      name_d        = name_q;
      cursor_d      = cursor_q;
      time_left_d   = time_left_q;
      start_cnt_d   = start_cnt_q;
      frame_cnt_d   = frame_cnt_q;
      owner_d       = owner_q;
      active_d      = active_q;
      round_reset_d = 1'b0;

      case (state_q)
         ST_WELCOME: begin
            if (p_chop[0]) begin
               state_d       = ST_START;
               active_d      = nump_eff;
               round_reset_d = 1'b1;
               time_left_d   = TIME_INIT;
               start_cnt_d   = '0;
               frame_cnt_d   = '0;
            end else if (p_up[0]) begin
               name_d[cursor_q] = (name_q[cursor_q] == CH_A) ? CH_Z : name_q[cursor_q] - 8'd1;
            end else if (p_down[0]) begin
               name_d[cursor_q] = (name_q[cursor_q] == CH_Z) ? CH_A : name_q[cursor_q] + 8'd1;
            end else if (p_right[0]) begin
               if (cursor_q != CUR_LAST) cursor_d = cursor_q + CUR_W'(1);
            end else if (p_left[0]) begin
               if (cursor_q != '0) cursor_d = cursor_q - CUR_W'(1);
            end
         end
         ST_START: begin
            if (frame_tick_i) begin
               if (start_cnt_q == START_LAST) begin
                  start_cnt_d = START_DONE;
                  state_d     = ST_PLAY;
               end else begin
                  start_cnt_d = start_cnt_q + SC_W'(1);
               end
            end
         end
         ST_PLAY: begin
            // Expiry is checked first so it beats a simultaneous pause.
            if (time_left_q == '0) begin
               state_d = ST_FINISH;
            end else begin
               if (frame_tick_i) begin
                  if (frame_cnt_q == FRAME_LAST) begin
                     frame_cnt_d = '0;
                     time_left_d = time_left_q - TIME_W'(1);
                  end else begin
                     frame_cnt_d = frame_cnt_q + FC_W'(1);
                  end
               end
               if (pause_req) begin
                  state_d = ST_PAUSE;
                  owner_d = pause_idx;
               end
            end
         end
         ST_PAUSE: begin
            if (p_chop[owner_q] && !carry_i[owner_q]) state_d = ST_PLAY;
         end
         ST_FINISH: begin
            if (p_chop[0]) begin
               state_d     = ST_WELCOME;
               cursor_d    = '0;
               time_left_d = TIME_INIT;
            end
         end
         default: state_d = ST_WELCOME;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= ST_WELCOME;
         name_q        <= {NAME_LEN{CH_A}};
         cursor_q      <= '0;
         time_left_q   <= TIME_INIT;
         start_cnt_q   <= '0;
         frame_cnt_q   <= '0;
         owner_q       <= '0;
         active_q      <= PW'(1);
         round_reset_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         name_q        <= name_d;
         cursor_q      <= cursor_d;
         time_left_q   <= time_left_d;
         start_cnt_q   <= start_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         owner_q       <= owner_d;
         active_q      <= active_d;
         round_reset_q <= round_reset_d;
      end
   end

`ifdef GAME_FLOW_HISCORE_EN
   logic [9:0] best_q;

   // Keep the best round total, captured on the FINISH-entry edge.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         best_q <= '0;
      end else if (state_q != ST_FINISH && state_d == ST_FINISH && score_i > best_q) begin
         best_q <= score_i;
      end
   end

   assign best_score_o = best_q;
`else
   logic unused_score;
   assign unused_score = ^score_i;
   assign best_score_o = '0;
`endif

   assign game_state_o     = state_q;
   assign team_name_o      = name_q;
   assign name_cursor_o    = cursor_q;
   assign time_left_o      = time_left_q;
   assign timer_go_o       = (state_q == ST_PLAY);
   assign players_frozen_o = (state_q != ST_PLAY);
   assign round_reset_o    = round_reset_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed bench for game_flow_ctrl with an expected-value
// queue. Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a cycle after the active rising edge.
// Define GAME_FLOW_HISCORE_EN to expect the best-score register.
module tb_game_flow_ctrl;

   localparam int NP = 4;

   localparam int B_LEFT  = 0;
   localparam int B_RIGHT = 1;
   localparam int B_UP    = 2;
   localparam int B_DOWN  = 3;
   localparam int B_CHOP  = 4;
   localparam int B_CARRY = 5;

`ifdef GAME_FLOW_HISCORE_EN
   localparam logic [31:0] BEST_EXP = 32'd40;
`else
   localparam logic [31:0] BEST_EXP = 32'd0;
`endif

   logic          clk;
   logic          rst_n;
   logic          frame_tick;
   logic [2:0]    num_players;
   logic [NP-1:0] left, right, up, down, chop, carry;
   logic [9:0]    score;
   logic [2:0]    game_state;
   logic [23:0]   team_name;
   logic [1:0]    name_cursor;
   logic [7:0]    time_left;
   logic          timer_go;
   logic          players_frozen;
   logic          round_reset;
   logic [9:0]    best_score;

   game_flow_ctrl dut (
      .clock_i          (clk),
      .reset_ni         (rst_n),
      .frame_tick_i     (frame_tick),
      .num_players_i    (num_players),
      .left_i           (left),
      .right_i          (right),
      .up_i             (up),
      .down_i           (down),
      .chop_i           (chop),
      .carry_i          (carry),
      .score_i          (score),
      .game_state_o     (game_state),
      .team_name_o      (team_name),
      .name_cursor_o    (name_cursor),
      .time_left_o      (time_left),
      .timer_go_o       (timer_go),
      .players_frozen_o (players_frozen),
      .round_reset_o    (round_reset),
      .best_score_o     (best_score)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard
   logic [31:0] exp_q[$];
   int n_vec  = 0;
   int n_miss = 0;

   task automatic expect_val(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp_v;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_miss++;
         $error("FAIL %s: observed %0h, expected queue empty", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
         end
      end
   endtask

   // Drivers
   task automatic set_btn(input int sel, input int p, input logic v);
      case (sel)
         B_LEFT:  left[p]  = v;
         B_RIGHT: right[p] = v;
         B_UP:    up[p]    = v;
         B_DOWN:  down[p]  = v;
         B_CHOP:  chop[p]  = v;
         default: carry[p] = v;
      endcase
   endtask

   task automatic tap(input int sel, input int p);
      set_btn(sel, p, 1'b1);
      @(negedge clk);
      set_btn(sel, p, 1'b0);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      frame_tick = 1'b1;
      repeat (n) @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic pause_press(input int p);
      chop[p]  = 1'b1;
      carry[p] = 1'b1;
      @(negedge clk);
   endtask

   task automatic pause_release(input int p);
      chop[p]  = 1'b0;
      carry[p] = 1'b0;
      @(negedge clk);
   endtask

   // Directed sequence
   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; num_players = 3'd2; score = 10'd0;
      left = '0; right = '0; up = '0; down = '0; chop = '0; carry = '0;
      repeat (2) @(negedge clk);

      // Reset values
      expect_val(32'd0);       check("rst_state",  32'(game_state));
      expect_val(32'h414141);  check("rst_name",   32'(team_name));
      expect_val(32'd0);       check("rst_cursor", 32'(name_cursor));
      expect_val(32'd180);     check("rst_time",   32'(time_left));
      expect_val(32'd0);       check("rst_go",     32'(timer_go));
      expect_val(32'd1);       check("rst_frozen", 32'(players_frozen));
      expect_val(32'd0);       check("rst_rr",     32'(round_reset));
      expect_val(32'd0);       check("rst_best",   32'(best_score));
      rst_n = 1'b1;
      @(negedge clk);

      // Round 1 with two players: masking, then reset mid-PLAY at 97 s
      expect_val(32'd1);  tap(B_CHOP, 0);   check("r1_start", 32'(game_state));
      expect_val(32'd2);  ticks(300);       check("r1_play", 32'(game_state));
      expect_val(32'd97); ticks(83 * 60);   check("r1_time97", 32'(time_left));
      expect_val(32'd2);
      pause_press(3); pause_release(3);
      check("mask_p3_ignored", 32'(game_state));
      #2 rst_n = 1'b0;
      expect_val(32'd0); expect_val(32'h414141); expect_val(32'd180); expect_val(32'd1);
      #1;
      check("areset_state",  32'(game_state));
      check("areset_name",   32'(team_name));
      check("areset_time",   32'(time_left));
      check("areset_frozen", 32'(players_frozen));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Name entry
      expect_val(32'h5A); tap(B_UP, 0); check("up_wrap_z", 32'(team_name[7:0]));
      expect_val(32'd1); expect_val(32'h43);
      tap(B_RIGHT, 0); tap(B_DOWN, 0); tap(B_DOWN, 0);
      check("cursor1", 32'(name_cursor));
      check("char1_c", 32'(team_name[15:8]));
      expect_val(32'd2);
      repeat (5) tap(B_RIGHT, 0);
      check("cursor_sat", 32'(name_cursor));
      expect_val(32'h42435A);
      down[0] = 1'b1;
      repeat (100) @(negedge clk);
      down[0] = 1'b0;
      @(negedge clk);
      check("hold_one_inc", 32'(team_name));

      // START countdown with four players
      score = 10'd40; num_players = 3'd4;
      expect_val(32'd1); expect_val(32'd1);
      chop[0] = 1'b1;
      @(negedge clk);
      check("start_state", 32'(game_state));
      check("rr_high", 32'(round_reset));
      chop[0] = 1'b0;
      expect_val(32'd0);
      @(negedge clk);
      check("rr_one_cycle", 32'(round_reset));
      expect_val(32'd1); ticks(299); check("start_299", 32'(game_state));
      expect_val(32'd2); expect_val(32'd1); expect_val(32'd0); expect_val(32'd180);
      ticks(1);
      check("play_300", 32'(game_state));
      check("play_go", 32'(timer_go));
      check("play_frozen", 32'(players_frozen));
      check("play_time", 32'(time_left));

      // Round timer to expiry
      expect_val(32'd179); ticks(60); check("time_179", 32'(time_left));
      expect_val(32'd0); expect_val(32'd2);
      ticks(179 * 60);
      check("time_zero", 32'(time_left));
      check("zero_still_play", 32'(game_state));
      expect_val(32'd4); expect_val(32'd0); expect_val(BEST_EXP);
      @(negedge clk);
      check("finish_state", 32'(game_state));
      check("finish_go", 32'(timer_go));
      check("best_round1", 32'(best_score));

      // FINISH back to WELCOME, then a new round for pause ownership
      expect_val(32'd0); expect_val(32'd0); expect_val(32'd180); expect_val(32'h42435A);
      tap(B_CHOP, 0);
      check("fin_welcome", 32'(game_state));
      check("fin_cursor", 32'(name_cursor));
      check("fin_time", 32'(time_left));
      check("fin_name_kept", 32'(team_name));
      expect_val(32'd1); tap(B_CHOP, 0); check("r3_start", 32'(game_state));
      num_players = 3'd1;
      expect_val(32'd2); ticks(300); check("r3_play", 32'(game_state));
      ticks(30);
      expect_val(32'd3); expect_val(32'd0);
      pause_press(2);
      check("pause_p2", 32'(game_state));
      check("pause_go", 32'(timer_go));
      pause_release(2);
      expect_val(32'd3); expect_val(32'd180);
      ticks(100);
      check("pause_ticks_state", 32'(game_state));
      check("pause_ticks_time", 32'(time_left));
      expect_val(32'd3); tap(B_CHOP, 0); check("pause_p0_chop", 32'(game_state));
      expect_val(32'd2); tap(B_CHOP, 2); check("resume_p2", 32'(game_state));
      expect_val(32'd180); ticks(29); check("resume_frame_held", 32'(time_left));
      expect_val(32'd179); ticks(1);  check("resume_wrap", 32'(time_left));

      // Pause on the cycle time_left sits at 0: FINISH wins
      score = 10'd25;
      expect_val(32'd0); ticks(179 * 60); check("r3_time_zero", 32'(time_left));
      expect_val(32'd4); expect_val(BEST_EXP);
      pause_press(2);
      check("expiry_beats_pause", 32'(game_state));
      check("best_kept", 32'(best_score));
      pause_release(2);
      expect_val(32'd0); tap(B_CHOP, 0); check("final_welcome", 32'(game_state));

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
